// File: rtl/fir_seq_ctrl.sv
// rtl/fir_seq_ctrl.sv - FIR chain sequencer: nibble-serial issue, result capture, output FIFO, coefficient bank
module fir_seq_ctrl #(
  parameter int NTAP    = 8,
  parameter int DISCARD = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_vld,
  output logic              in_rdy,
  output logic              pe_rdy,
  output logic [3:0]        pe_xin,
  output logic [3:0]        pe_yin,
  input  logic              chain_rdy,
  input  logic [3:0]        chain_yout,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [7:0]        cfg_data,
  output logic [8*NTAP-1:0] coef_bus,
  output logic [15:0]       out_data,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              busy,
  output logic              ovf,
  output logic              cfg_err
);

  typedef enum logic [1:0] {IDLE, START, SHIFT} state_t;

  localparam int DW = $clog2(DISCARD + 2);

  state_t      state, state_nxt;
  logic [1:0]  nc, nc_nxt;
  logic [7:0]  sample, sample_nxt;

  logic        cap_active;
  logic [1:0]  cap_cnt;
  logic [15:0] asm_q;
  logic [15:0] res_data;
  logic        res_done;
  logic [DW-1:0] disc_cnt;
  logic        push;

  logic [15:0] fifo_mem [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;
  logic        full, pop, wr_en;

  logic [7:0]  coef [NTAP];
  logic        cfg_ok;

  // ---------------- issue FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      nc     <= 2'd0;
      sample <= 8'h00;
    end else begin
      state  <= state_nxt;
      nc     <= nc_nxt;
      sample <= sample_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    nc_nxt     = nc;
    sample_nxt = sample;
    in_rdy     = 1'b0;
    pe_rdy     = 1'b0;
    pe_xin     = 4'h0;
    pe_yin     = 4'h0;
    case (state)
      IDLE: begin
        in_rdy = 1'b1;
      end
      START: begin
        pe_rdy    = 1'b1;
        state_nxt = SHIFT;
        nc_nxt    = 2'd0;
      end
      SHIFT: begin
        case (nc)
          2'd0:    pe_xin = sample[3:0];
          2'd1:    pe_xin = sample[7:4];
          default: pe_xin = 4'h0;
        endcase
        nc_nxt = nc + 2'd1;
        if (nc == 2'd3) begin
          in_rdy    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // An accepted sample always restarts a frame, from IDLE or the last SHIFT cycle.
    if (in_rdy && in_vld) begin
      sample_nxt = in_data;
      state_nxt  = START;
    end
  end

  assign busy = (state != IDLE);

  // ---------------- result capture ----------------
  assign res_data = {chain_yout, asm_q[15:4]};
  assign res_done = cap_active && (cap_cnt == 2'd3);
  assign push     = res_done && (disc_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_active <= 1'b0;
      cap_cnt    <= 2'd0;
      asm_q      <= 16'h0000;
      disc_cnt   <= DW'(DISCARD);
    end else begin
      if (cap_active) begin
        asm_q   <= res_data;
        cap_cnt <= cap_cnt + 2'd1;
        if (cap_cnt == 2'd3) cap_active <= 1'b0;
      end else if (chain_rdy) begin
        cap_active <= 1'b1;
        cap_cnt    <= 2'd0;
      end
      if (res_done && (disc_cnt != '0)) disc_cnt <= disc_cnt - DW'(1);
    end
  end

  // ---------------- 2-entry output FIFO ----------------
  assign full     = (count == 2'd2);
  assign pop      = out_vld && out_rdy;
  assign wr_en    = push && (!full || pop);
  assign out_vld  = (count != 2'd0);
  assign out_data = out_vld ? fifo_mem[rd_ptr] : 16'h0000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) fifo_mem[i] <= 16'h0000;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) begin
        fifo_mem[wr_ptr] <= res_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({wr_en, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (push && full && !pop) ovf <= 1'b1;
    end
  end

  // ---------------- coefficient bank ----------------
  assign cfg_ok = !busy && (32'(cfg_addr) < NTAP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NTAP; k++) coef[k] <= 8'h00;
      cfg_err <= 1'b0;
    end else if (cfg_we) begin
      if (cfg_ok) begin
        for (int k = 0; k < NTAP; k++)
          if (32'(cfg_addr) == k) coef[k] <= cfg_data;
      end else begin
        cfg_err <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NTAP; k++) begin : g_coef
    assign coef_bus[8*k +: 8] = coef[k];
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb/tb_fir_seq_ctrl.sv - scoreboard bench for fir_seq_ctrl
module tb_fir_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic        pe_rdy;
  logic [3:0]  pe_xin, pe_yin;
  logic        chain_rdy = 1'b0;
  logic [3:0]  chain_yout = 4'h0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = 3'd0;
  logic [7:0]  cfg_data = 8'h00;
  logic [63:0] coef_bus;
  logic [15:0] out_data;
  logic        out_vld;
  logic        out_rdy = 1'b1;
  logic        busy, ovf, cfg_err;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sb [$];
  logic [15:0] exp_v;
  logic [16:0] rdy_mask, pe_mask;
  int          acc;

  always #5 clk = ~clk;

  fir_seq_ctrl #(.NTAP(8), .DISCARD(2)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
    .pe_rdy(pe_rdy), .pe_xin(pe_xin), .pe_yin(pe_yin), .chain_rdy(chain_rdy),
    .chain_yout(chain_yout), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .coef_bus(coef_bus), .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
    .busy(busy), .ovf(ovf), .cfg_err(cfg_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output must match the oldest expected result
  always @(negedge clk) begin
    if (!reset && out_vld && out_rdy) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got %0h expected none", out_data);
      end else begin
        exp_v = sb.pop_front();
        check("out_data", {48'h0, out_data}, {48'h0, exp_v});
      end
    end
  end

  // Plays the last PE: frame pulse, then four nibbles low first
  task automatic send_result(input logic [15:0] v, input bit pop_mid);
    @(posedge clk) #1; chain_rdy = 1'b1;
    @(posedge clk) #1; chain_rdy = 1'b0; chain_yout = v[3:0];
    @(posedge clk) #1; chain_yout = v[7:4];
    @(posedge clk) #1; chain_yout = v[11:8];
    @(posedge clk) #1; chain_yout = v[15:12]; if (pop_mid) out_rdy = 1'b1;
    @(posedge clk) #1; chain_yout = 4'h0;     if (pop_mid) out_rdy = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_outs", {in_rdy, pe_rdy, pe_xin, pe_yin, out_vld, busy, ovf, cfg_err}, 14'h2000);
    check("reset_data", out_data, 16'h0000);
    check("reset_coef", coef_bus, 64'h0);

    // priming results are dropped, third one reaches the output
    send_result(16'hDEAD, 1'b0);
    send_result(16'hBEEF, 1'b0);
    check("discard_vld", out_vld, 1'b0);
    sb.push_back(16'h1234);
    send_result(16'h1234, 1'b0);
    check("result_vld", out_vld, 1'b1);
    @(posedge clk) #1;
    check("drain_empty", out_vld, 1'b0);

    // single frame timing for sample A5
    @(posedge clk) #1; in_vld = 1'b1; in_data = 8'hA5;
    @(negedge clk); check("c0_in_rdy", in_rdy, 1'b1);
    @(posedge clk) #1; in_vld = 1'b0;
    @(negedge clk); check("c1_start", {pe_rdy, busy, pe_xin}, 6'b110000);
    @(negedge clk); check("c2_xin", {pe_rdy, pe_xin}, 5'h05);
    @(negedge clk); check("c3_xin", {pe_rdy, pe_xin}, 5'h0A);
    @(negedge clk); check("c4_xin", {in_rdy, pe_xin}, 5'h00);
    @(negedge clk); check("c5_xin", {in_rdy, pe_xin}, 5'h10);
    @(negedge clk); check("c6_idle", busy, 1'b0);

    // back-to-back: three samples with in_vld held high
    @(posedge clk) #1; in_vld = 1'b1; in_data = 8'h11;
    acc = 0; rdy_mask = '0; pe_mask = '0;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      rdy_mask[c] = in_rdy;
      pe_mask[c]  = pe_rdy;
      if (in_vld && in_rdy) acc++;
      @(posedge clk) #1;
      if (acc == 3) in_vld = 1'b0;
      else in_data = in_data + 8'h11;
    end
    check("b2b_pe_rdy", pe_mask, 17'h00842);
    check("b2b_in_rdy", rdy_mask, 17'h18421);

    // FIFO full: simultaneous push/pop is clean, a push with no pop overflows
    out_rdy = 1'b0;
    sb.push_back(16'h0A0A); send_result(16'h0A0A, 1'b0);
    sb.push_back(16'h0B0B); send_result(16'h0B0B, 1'b0);
    check("full_no_ovf", {out_vld, ovf}, 2'b10);
    sb.push_back(16'h0C0C); send_result(16'h0C0C, 1'b1);
    check("pushpop_no_ovf", ovf, 1'b0);
    send_result(16'h0D0D, 1'b0);
    check("drop_ovf", ovf, 1'b1);
    out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("drain2_empty", out_vld, 1'b0);

    // coefficient writes idle vs busy
    @(posedge clk) #1; cfg_we = 1'b1; cfg_addr = 3'd3; cfg_data = 8'h7F;
    @(posedge clk) #1; cfg_we = 1'b0;
    check("cfg_idle", coef_bus, 64'h0000_0000_7F00_0000);
    check("cfg_err_idle", cfg_err, 1'b0);
    in_vld = 1'b1; in_data = 8'h3C;
    @(posedge clk) #1; in_vld = 1'b0;
    cfg_we = 1'b1; cfg_addr = 3'd3; cfg_data = 8'h11;
    @(posedge clk) #1; cfg_we = 1'b0;
    check("cfg_busy", coef_bus, 64'h0000_0000_7F00_0000);
    check("cfg_err_busy", cfg_err, 1'b1);
    repeat (6) @(posedge clk);
    #1;

    // asynchronous reset during SHIFT nc=1
    out_rdy = 1'b0;
    send_result(16'h5A5A, 1'b0);
    check("pre_rst_vld", out_vld, 1'b1);
    @(posedge clk) #1; in_vld = 1'b1; in_data = 8'hA5;
    @(posedge clk) #1; in_vld = 1'b0;
    @(posedge clk) #1;
    @(posedge clk) #1;
    check("pre_rst_xin", {busy, pe_xin}, 5'h1A);
    #2 reset = 1'b1;
    #1 check("async_rst", {pe_rdy, pe_xin, busy, out_vld}, 7'h00);
    @(posedge clk) #1; reset = 1'b0; out_rdy = 1'b1;
    check("post_rst_flags", {ovf, cfg_err, in_rdy}, 3'b001);
    check("post_rst_coef", coef_bus, 64'h0);

    // discard counter is rearmed by reset
    send_result(16'h9999, 1'b0);
    send_result(16'h8888, 1'b0);
    sb.push_back(16'h4321);
    send_result(16'h4321, 1'b0);
    @(posedge clk) #1;
    check("final_vld", out_vld, 1'b0);
    check("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
